// File: rtl/running_mean_unit.sv
// running_mean_unit: sliding-window mean of the last N accepted distances (RUNNING_MEAN_ROUND_EN selects round-half-up).
module running_mean_unit #(
  parameter int B = 32,
  parameter int N = 8,
  localparam int LOG2N = $clog2(N)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [B-1:0]     dist_in,
  input  logic             dist_valid,
  output logic             dist_ready,
  input  logic             flush,
  output logic [B-1:0]     running_mean,
  output logic             running_mean_valid,
  output logic [LOG2N:0]   sample_count
);
  typedef enum logic [1:0] {EMPTY, FILLING, FULL} state_t;
  state_t state;
  logic [B-1:0] window [N];
  logic [LOG2N-1:0] wr_ptr;
  logic [B+LOG2N-1:0] sum, sum_next, dist_ext, old_ext;
  logic [B-1:0] mean_next;
  logic accept;
  assign dist_ready = !flush && !reset;
  assign accept = dist_valid && dist_ready;
  assign dist_ext = {{LOG2N{1'b0}}, dist_in};
  // the oldest sample only leaves the sum once the window is full
  assign old_ext = state == FULL ? {{LOG2N{1'b0}}, window[wr_ptr]} : '0;
  assign sum_next = sum + dist_ext - old_ext;
`ifdef RUNNING_MEAN_ROUND_EN
  localparam logic [B+LOG2N:0] HALF = (B+LOG2N+1)'(N >> 1);
  logic [B+LOG2N:0] rounded;
  logic [B:0] quot;
  assign rounded = {1'b0, sum_next} + HALF;
  assign quot = rounded[B+LOG2N:LOG2N];
  assign mean_next = quot[B] ? '1 : quot[B-1:0];
`else
  assign mean_next = sum_next[B+LOG2N-1:LOG2N];
`endif
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      state <= EMPTY;
      sum <= '0;
      wr_ptr <= '0;
      sample_count <= '0;
      running_mean <= '0;
      running_mean_valid <= 1'b0;
    end else if (accept) begin
      window[wr_ptr] <= dist_in;
      wr_ptr <= wr_ptr + 1'b1;
      sum <= sum_next;
      running_mean <= mean_next;
      if (state != FULL) begin
        sample_count <= sample_count + 1'b1;
        state <= sample_count == (LOG2N+1)'(N-1) ? FULL : FILLING;
        running_mean_valid <= sample_count == (LOG2N+1)'(N-1);
      end
    end
  end
endmodule
